// File: rtl/state_dump_unit.sv
// state_dump_unit: walks the register file, then data memory, as tagged beats.
// Define DUMP_CHECKSUM_EN to append an XOR checksum beat (tag 6'h3F).
module state_dump_unit #(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 16,
  parameter int DATA_W        = 32,
  parameter int DM_AW         = $clog2(NUM_MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4:0]        rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic              dm_rd_en_o,
  output logic [DM_AW-1:0]  dm_rd_addr_o,
  input  logic [DATA_W-1:0] dm_rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [5:0]        out_tag_o,
  output logic              out_last_o
);

  localparam int MAX_N =
    (NUM_REGS > NUM_MEM_WORDS) ? NUM_REGS : NUM_MEM_WORDS;
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(NUM_MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RF,
    MEM_REQ,
    MEM_WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [5:0]        out_tag_q, out_tag_d;
  logic              out_last_q, out_last_d;

  logic              slot_free;
  logic              hs_last;
  logic              start_go;
  logic              dm_en;

  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [5:0]        load_tag;
  logic              load_last;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              ck_pend_q, ck_pend_d;
`endif

  assign slot_free = !out_valid_q || out_ready_i;
  assign hs_last   = out_valid_q && out_ready_i && out_last_q;
  // done_q marks the pulse cycle; a start seen then is dropped
  assign start_go  = (state_q == IDLE) && start_i && !done_q;

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_tag_o    = out_tag_q;
  assign out_last_o   = out_last_q;
  assign dm_rd_en_o   = dm_en;
  assign rf_rd_addr_o = (state_q == RF) ? 5'(index_q) : 5'd0;
  assign dm_rd_addr_o = dm_en ? DM_AW'(index_q) : '0;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dm_en     = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_tag  = '0;
    load_last = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    ck_pend_d = ck_pend_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = RF;
          index_d = '0;
          busy_d  = 1'b1;
        end
      end

      RF: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = rf_rd_data_i;
          load_tag  = {1'b0, 5'(index_q)};
          if (index_q == RF_LAST) begin
            index_d = '0;
            state_d = MEM_REQ;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      MEM_REQ: begin
        if (slot_free) begin
          dm_en   = 1'b1;
          state_d = MEM_WAIT;
        end
      end

      // The strobe cycle emptied the slot, so the load is unconditional
      MEM_WAIT: begin
        load      = 1'b1;
        load_data = dm_rd_data_i;
        load_tag  = {1'b1, 5'(index_q)};
        if (index_q == DM_LAST) begin
          index_d = '0;
          state_d = DONE;
`ifdef DUMP_CHECKSUM_EN
          ck_pend_d = 1'b1;
`else
          load_last = 1'b1;
`endif
        end else begin
          index_d = index_q + 1'b1;
          state_d = MEM_REQ;
        end
      end

      DONE: begin
`ifdef DUMP_CHECKSUM_EN
        if (ck_pend_q) begin
          if (slot_free) begin
            load      = 1'b1;
            load_data = csum_q;
            load_tag  = 6'h3F;
            load_last = 1'b1;
            ck_pend_d = 1'b0;
          end
        end else if (hs_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`else
        if (hs_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_tag_d   = load_tag;
      out_last_d  = load_last;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (start_go) begin
      csum_d = '0;
    end else if (load && state_q != DONE) begin
      csum_d = csum_q ^ load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q    <= '0;
      ck_pend_q <= 1'b0;
    end else begin
      csum_q    <= csum_d;
      ck_pend_q <= ck_pend_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: directed bench with a queue model of the dump stream.
// Honours DUMP_CHECKSUM_EN the same way as the design.
module tb_state_dump_unit;

  localparam int NR = 32;
  localparam int NM = 16;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NBEATS = NR + NM + (CK ? 1 : 0);
  localparam int NCYC   = NR + 2 * NM + 1 + (CK ? 1 : 0);

  typedef struct packed {
    logic [5:0]    tag;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [4:0]    rf_rd_addr_o;
  logic [DW-1:0] rf_rd_data_i;
  logic          dm_rd_en_o;
  logic [3:0]    dm_rd_addr_o;
  logic [DW-1:0] dm_rd_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [5:0]    out_tag_o;
  logic          out_last_o;

  logic [DW-1:0] rf  [NR];
  logic [DW-1:0] mem [NM];
  beat_t         exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  bit   mon_en = 1'b0;
  logic [5:0]    last_tag = '0;
  logic [DW-1:0] last_data = '0;

  state_dump_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_i (rf_rd_data_i),
    .dm_rd_en_o   (dm_rd_en_o),
    .dm_rd_addr_o (dm_rd_addr_o),
    .dm_rd_data_i (dm_rd_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_tag_o    (out_tag_o),
    .out_last_o   (out_last_o)
  );

  always #5 clk = ~clk;

  assign rf_rd_data_i = rf[rf_rd_addr_o];

  always @(posedge clk) begin
    if (dm_rd_en_o) dm_rd_data_i <= mem[dm_rd_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected stream: every register, every memory word, then optional XOR
  task automatic build_expect();
    beat_t b;
    logic [DW-1:0] x;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < NR; i++) begin
      b.tag  = 6'(i);
      b.data = rf[i];
      b.last = 1'b0;
      x ^= rf[i];
      exp_q.push_back(b);
    end
    for (int j = 0; j < NM; j++) begin
      b.tag  = 6'(32 + j);
      b.data = mem[j];
      b.last = (j == NM - 1) && !CK;
      x ^= mem[j];
      exp_q.push_back(b);
    end
    if (CK) begin
      b.tag  = 6'h3F;
      b.data = x;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic start_dump();
    build_expect();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done_o) begin
        seen = 1'b1;
        chk("done_busy_low", busy_o, 0);
        chk("queue_drained", exp_q.size(), 0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_o");
    end
  endtask

  task automatic wait_beat(input logic [5:0] tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid_o && out_tag_o == tag) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=none required=tag_%0h", tag);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_done"}, done_o, 0);
    chk({pfx, "_valid"}, out_valid_o, 0);
    chk({pfx, "_data"}, out_data_o, 0);
    chk({pfx, "_tag"}, out_tag_o, 0);
    chk({pfx, "_last"}, out_last_o, 0);
    chk({pfx, "_dm_en"}, dm_rd_en_o, 0);
    chk({pfx, "_rf_addr"}, rf_rd_addr_o, 0);
    chk({pfx, "_dm_addr"}, dm_rd_addr_o, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) out_ready_i = 1'b1;
      else if (ready_mode == 1) out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: every handshake against the model, every stall for hold
  initial begin
    beat_t held;
    beat_t b;
    bit    held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (!mon_en) begin
        held_v = 1'b0;
        continue;
      end
      if (held_v) begin
        chk("stall_valid", out_valid_o, 1);
        chk("stall_data", out_data_o, held.data);
        chk("stall_tag", out_tag_o, held.tag);
        chk("stall_last", out_last_o, held.last);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=tag_%0h required=none",
                   out_tag_o);
        end else begin
          b = exp_q.pop_front();
          chk("beat_tag", out_tag_o, b.tag);
          chk("beat_data", out_data_o, b.data);
          chk("beat_last", out_last_o, b.last);
        end
        hs_cnt++;
        if (out_last_o) begin
          last_tag  = out_tag_o;
          last_data = out_data_o;
        end
      end
      held_v    = out_valid_o && !out_ready_i;
      held.tag  = out_tag_o;
      held.data = out_data_o;
      held.last = out_last_o;
    end
  end

  initial begin
    int n;
    int hs0;
    int d0;
    reset       = 1'b0;
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = 32'(i) * 32'h1111_1111;
    for (int j = 0; j < NM; j++) mem[j] = 32'hA000_0000 + 32'(j);

    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // Full dump, ready high
    hs0 = hs_cnt;
    d0  = done_cnt;
    start_dump();
    chk("model_rf10", exp_q[10].data, 32'hAAAA_AAAA);
    chk("model_mem0_tag", exp_q[32].tag, 6'h20);
    chk("model_mem15", exp_q[47].data, 32'hA000_000F);
    chk("busy_after_start", busy_o, 1);
    chk("idle_before_e1", out_valid_o, 0);
    @(posedge clk); #1;
    chk("first_valid", out_valid_o, 1);
    chk("first_tag", out_tag_o, 0);
    chk("first_data", out_data_o, 0);
    wait_done(200, n);
    chk("dump_cycles", n + 1, NCYC);
    chk("t1_beats", hs_cnt - hs0, NBEATS);
    @(posedge clk); #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("done_one_cycle", done_o, 0);
    if (CK) begin
      chk("t1_last_tag", last_tag, 6'h3F);
    end else begin
      chk("t1_last_tag", last_tag, 6'h2F);
      chk("t1_last_data", last_data, 32'hA000_000F);
    end

    // Backpressure at beat 10
    hs0 = hs_cnt;
    start_dump();
    wait_beat(6'h0A, 100);
    ready_mode  = 2;
    out_ready_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_rf_addr", rf_rd_addr_o, 5'd11);
    end
    chk("stall_tag_0a", out_tag_o, 6'h0A);
    chk("stall_data_rf10", out_data_o, 32'hAAAA_AAAA);
    out_ready_i = 1'b1;
    ready_mode  = 0;
    wait_done(200, n);
    chk("t2_beats", hs_cnt - hs0, NBEATS);

    // Random ready
    ready_mode = 1;
    hs0 = hs_cnt;
    start_dump();
    wait_done(3000, n);
    chk("t3_beats", hs_cnt - hs0, NBEATS);
    ready_mode = 0;

    // Start while busy, and in the done cycle
    hs0 = hs_cnt;
    start_dump();
    repeat (20) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    chk("busy_mid", busy_o, 1);
    wait_done(200, n);
    chk("t4a_beats", hs_cnt - hs0, NBEATS);
    build_expect();
    hs0 = hs_cnt;
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("start_in_done_ignored", busy_o, 0);
    @(posedge clk); #1 start_i = 1'b0;
    chk("start_next_accepted", busy_o, 1);
    wait_done(200, n);
    chk("t4b_cycles", n, NCYC);
    chk("t4b_beats", hs_cnt - hs0, NBEATS);

    // Reset at memory beat 3
    start_dump();
    wait_beat(6'h23, 200);
    mon_en = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - d0, 0);
    mon_en = 1'b1;
    hs0 = hs_cnt;
    start_dump();
    @(posedge clk); #1;
    chk("restart_valid", out_valid_o, 1);
    chk("restart_tag", out_tag_o, 0);
    wait_done(200, n);
    chk("t5_beats", hs_cnt - hs0, NBEATS);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < NR; i++) rf[i] = '0;
    for (int j = 0; j < NM; j++) mem[j] = 32'h1 << j;
    hs0 = hs_cnt;
    start_dump();
    chk("model_csum", exp_q[NBEATS-1].data, 32'h0000_FFFF);
    wait_done(200, n);
    chk("t6_beats", hs_cnt - hs0, NBEATS);
    chk("csum_tag", last_tag, 6'h3F);
    chk("csum_data", last_data, 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
# state_dump_unit

Hardware debug readout engine that walks the CPU's architectural state and streams it out as tagged 32-bit words over a valid/ready interface. On a start pulse it reads every register-file entry through a spare read port, then every data-memory word through a spare synchronous read port. It sits beside the pipeline and feeds a host link or capture FIFO. It is the in-silicon counterpart of the bench-side register and memory dump, so the same state is observable on hardware.

## Interface
- NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1)
- NUM_MEM_WORDS, 16, data-memory words dumped (word indices 0..NUM_MEM_WORDS-1)
- DATA_W, 32, word width
- clk  in  1  single clock; all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- start_i  in  1  begin a dump; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle pulse after the final beat handshakes
- rf_rd_addr_o  out  5  register-file read address; combinational read, data valid the same cycle
- rf_rd_data_i  in  DATA_W  register-file read data
- dm_rd_en_o  out  1  data-memory read strobe
- dm_rd_addr_o  out  $clog2(NUM_MEM_WORDS)  data-memory word index
- dm_rd_data_i  in  DATA_W  valid the cycle after dm_rd_en_o; held until the next strobe
- out_valid_o  out  1  stream beat valid
- out_ready_i  in  1  sink accepts beat
- out_data_o  out  DATA_W  beat payload
- out_tag_o  out  6  bit5=0 register / 1 memory; [4:0]=index; 6'h3F=checksum
- out_last_o  out  1  final beat of the dump

## Operation
- FSM states: IDLE, RF, MEM_REQ, MEM_WAIT, DONE.
- IDLE: start_i=1 -> RF, index cleared, busy_o=1. start_i is ignored in every other state.
- Output slot free = !out_valid_o || out_ready_i. A beat is loaded only when the slot is free. While out_valid_o=1 && out_ready_i=0, data, tag and last hold stable.
- RF: rf_rd_addr_o=index. When the slot is free, load rf_rd_data_i with tag {1'b0,index}, then index++. After index NUM_REGS-1 is loaded, clear index and go to MEM_REQ.
- MEM_REQ: when the slot is free, pulse dm_rd_en_o with dm_rd_addr_o=index, then go to MEM_WAIT.
- MEM_WAIT: load dm_rd_data_i with tag {1'b1,index} (slot is guaranteed free). index++. Return to MEM_REQ, or go to DONE after the last word (or after the checksum beat when enabled).
- DONE: wait until the final beat handshakes. Then done_o=1 for one cycle, busy_o=0, return to IDLE.
- out_last_o is set on the final beat only.
- The index counter is wide enough for max(NUM_REGS, NUM_MEM_WORDS). No wrap occurs within a dump.

## Timing
- Reset (asserted low, asynchronous): state=IDLE, index=0, and all outputs 0: busy_o, done_o, out_valid_o, out_data_o, out_tag_o, out_last_o, dm_rd_en_o, rf_rd_addr_o, dm_rd_addr_o. Reset mid-dump aborts immediately with no done_o.
- Start sampled at edge E0. First beat (x0) valid after E1.
- With out_ready_i held high:
  - register beats occupy 32 consecutive cycles;
  - each memory beat takes 2 cycles (strobe, then load);
  - total is 32 + 2·16 = 64 beat-cycles, plus 1 when checksum is enabled.
- done_o asserts the cycle after the last handshake. A start_i in that same cycle is ignored; the next start is accepted one cycle later, in IDLE.
- Backpressure stalls the FSM without losing or duplicating beats. rf_rd_addr_o holds during a stall.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - a running XOR of every emitted payload is kept;
  - after the last memory beat, one extra beat carries the XOR with tag 6'h3F and out_last_o=1;
  - the accumulator clears on start.
- Undefined: no accumulator, and the last memory beat carries out_last_o=1.

## Test plan
- Reset then start, ready=1, RF[i]=i*0x11111111 (x0=0), MEM[j]=0xA000_0000+j -> 32 beats with tag 0x00..0x1F and matching data, then 16 beats with tag 0x20..0x2F and data 0xA0000000..0xA000000F; out_last only on the final beat; one done_o pulse.
- Ready held low for 5 cycles at beat 10 -> out_data=RF[10] and tag 0x0A stay stable; no beat skipped or repeated.
- Random ready (50%) over a full dump -> exactly 48 handshakes (49 with checksum), in order.
- start_i pulsed during busy, and again in the done_o cycle -> both ignored; a start one cycle later launches a new dump.
- Reset asserted at memory beat 3 -> all outputs 0 immediately; no done_o; a fresh start restarts from tag 0x00.
- DUMP_CHECKSUM_EN, RF all 0, MEM[j]=1<<j -> final beat has tag 0x3F, data 0x0000FFFF, out_last=1.
